// File: rtl/ripple_cnt_pkg.sv
// ripple_cnt_pkg: shared state encoding, defaults and modular predecessor for the ripple count monitor.
// Rev 1.0
`default_nettype none

package ripple_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam int DEF_WIDTH         = 4;
  localparam int DEF_STABLE_CYCLES = 2;
  localparam int DEF_WRAP_CNT_W    = 8;

  // (p - 1) mod 2^width, computed in 32 bits; callers truncate to their own width.
  function automatic logic [31:0] mod_pred(input logic [31:0] p, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (p - 32'd1) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ripple_count_monitor_sync_stable_filter.sv
// sync_stable_filter: two-flop synchronizer, stability run counter and new-value detector.
// Rev 1.0
`default_nettype none

module sync_stable_filter
  import ripple_cnt_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             accept_pulse,
  output logic [WIDTH-1:0] accepted_value
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_TARGET = RUN_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic             vld1_q, vld1_d;
  logic             vld2_q, vld2_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             have_q, have_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             accept_q, accept_d;
  logic             restart;
  logic             reach;

  // The vld bits mark when each sync stage holds a real sample rather than its reset value,
  // so a bus sitting at 0 through reset still needs the full settling time to be accepted.
  always_comb begin
    sync1_d = cnt_in;
    sync2_d = sync1_q;
    vld1_d  = 1'b1;
    vld2_d  = vld1_q;
    restart = !vld2_q || (sync1_q != sync2_q);
    if (!vld1_q) begin
      run_d = '0;
    end else if (restart) begin
      run_d = RUN_ONE;
    end else if (run_q != RUN_TARGET) begin
      run_d = run_q + RUN_ONE;
    end else begin
      run_d = run_q;
    end
    reach    = vld1_q && (run_d == RUN_TARGET) && (restart || (run_q != RUN_TARGET));
    accept_d = reach && (!have_q || (sync1_q != last_q));
    last_d   = accept_d ? sync1_q : last_q;
    have_d   = have_q | accept_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      vld1_q   <= 1'b0;
      vld2_q   <= 1'b0;
      run_q    <= '0;
      have_q   <= 1'b0;
      last_q   <= '0;
      accept_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      vld1_q   <= vld1_d;
      vld2_q   <= vld2_d;
      run_q    <= run_d;
      have_q   <= have_d;
      last_q   <= last_d;
      accept_q <= accept_d;
    end
  end

  assign accept_pulse   = accept_q;
  assign accepted_value = last_q;

endmodule

`default_nettype wire

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: tracks a filtered ripple down-count, flagging zero, wrap and skipped steps.
// Rev 1.0
`default_nettype none

module ripple_count_monitor
  import ripple_cnt_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int WRAP_CNT_W    = DEF_WRAP_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_err,
  input  logic [WIDTH-1:0]      cnt_in,
  output logic                  cnt_valid,
  output logic [WIDTH-1:0]      cnt_value,
  output logic                  locked,
  output logic                  zero_pulse,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic                  skip_err
);

  localparam logic [WRAP_CNT_W-1:0] WRAP_ONE = WRAP_CNT_W'(1);

  logic             accept_pulse;
  logic [WIDTH-1:0] accepted_value;
  logic [WIDTH-1:0] expected;

  state_t                state_q, state_d;
  logic                  cnt_valid_q, cnt_valid_d;
  logic [WIDTH-1:0]      cnt_value_q, cnt_value_d;
  logic                  locked_q, locked_d;
  logic                  zero_pulse_q, zero_pulse_d;
  logic                  wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic                  skip_err_q, skip_err_d;

  sync_stable_filter #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk            (clk),
    .rst            (rst),
    .cnt_in         (cnt_in),
    .accept_pulse   (accept_pulse),
    .accepted_value (accepted_value)
  );

  assign expected = WIDTH'(mod_pred(32'(cnt_value_q), WIDTH));

  always_comb begin
    state_d      = state_q;
    cnt_valid_d  = 1'b0;
    zero_pulse_d = 1'b0;
    wrap_pulse_d = 1'b0;
    cnt_value_d  = cnt_value_q;
    wrap_count_d = wrap_count_q;
    // Clear is applied first so a skip detected in the same cycle overrides it.
    skip_err_d   = skip_err_q && !clr_err;
    case (state_q)
      IDLE: begin
        if (en) state_d = ACQ;
      end
      ACQ: begin
        if (!en) begin
          state_d = IDLE;
        end else if (accept_pulse) begin
          cnt_value_d = accepted_value;
          cnt_valid_d = 1'b1;
          state_d     = TRACK;
        end
      end
      TRACK: begin
        if (!en) begin
          state_d = IDLE;
        end else if (accept_pulse) begin
          cnt_value_d = accepted_value;
          cnt_valid_d = 1'b1;
          if (accepted_value == expected) begin
            zero_pulse_d = (accepted_value == '0);
            if (cnt_value_q == '0) begin
              wrap_pulse_d = 1'b1;
              if (wrap_count_q != '1) wrap_count_d = wrap_count_q + WRAP_ONE;
            end
          end else begin
            skip_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_valid_q  <= 1'b0;
      cnt_value_q  <= '0;
      locked_q     <= 1'b0;
      zero_pulse_q <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= '0;
      skip_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_valid_q  <= cnt_valid_d;
      cnt_value_q  <= cnt_value_d;
      locked_q     <= locked_d;
      zero_pulse_q <= zero_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_count_q <= wrap_count_d;
      skip_err_q   <= skip_err_d;
    end
  end

  assign cnt_valid  = cnt_valid_q;
  assign cnt_value  = cnt_value_q;
  assign locked     = locked_q;
  assign zero_pulse = zero_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_count_q;
  assign skip_err   = skip_err_q;

endmodule

`default_nettype wire
